// File: rtl/mix_columns_seq_if.sv
// mix_columns_seq_if
//   Handshake bundle for the sequential AES MixColumns stage.
//   Upstream side : in_valid_i, in_ready_o, bypass_i, data_i
//   Downstream side: out_valid_o, out_ready_i, data_o
//   Signal names carry the direction as seen from the MixColumns block.
//   modport slave  - the MixColumns block itself
//   modport master - the environment driving states in and taking results out
interface mix_columns_seq_if #(
  parameter int WIDTH  = 8,
  parameter int N_COLS = 4
);
  localparam int STATE_W = WIDTH * 4 * N_COLS;

  logic               in_valid_i;
  logic               in_ready_o;
  logic               bypass_i;
  logic [STATE_W-1:0] data_i;
  logic               out_valid_o;
  logic               out_ready_i;
  logic [STATE_W-1:0] data_o;

  modport slave (
    input  in_valid_i, bypass_i, data_i, out_ready_i,
    output in_ready_o, out_valid_o, data_o
  );

  modport master (
    output in_valid_i, bypass_i, data_i, out_ready_i,
    input  in_ready_o, out_valid_o, data_o
  );
endinterface

// File: rtl/mix_columns_seq.sv
// mix_columns_seq
//   Sequential AES MixColumns: one 32-bit column per clock, four clocks per
//   128-bit state, result returned over a valid/ready handshake. A bypass
//   flag captured with the state passes it through unchanged (final round)
//   with identical latency.
//   Ports:
//     clk_i  - clock, rising edge
//     rst_ni - asynchronous active-low reset
//     bus    - mix_columns_seq_if.slave: in_valid_i/in_ready_o/bypass_i/data_i
//              on the input side, out_valid_o/out_ready_i/data_o on the output
//   Byte k of a state sits at data[127-8k -: 8]; column c holds bytes 4c..4c+3
//   with byte 4c in row 0 (most significant byte of the column).
module mix_columns_seq #(
  parameter int WIDTH  = 8,
  parameter int N_COLS = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  mix_columns_seq_if.slave bus
);

  localparam int COL_W   = 4 * WIDTH;
  localparam int CNT_W   = $clog2(N_COLS);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [1:0] OP_X1 = 2'b01;
  localparam logic [1:0] OP_X2 = 2'b10;
  localparam logic [1:0] OP_X3 = 2'b11;

  localparam logic [CNT_W-1:0] LAST_COL = CNT_W'(N_COLS - 1);

  if (WIDTH != 8) begin : g_bad_width
    $error("mix_columns_seq: WIDTH must be 8");
  end
  if (N_COLS != 4) begin : g_bad_cols
    $error("mix_columns_seq: N_COLS must be 4");
  end

  // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1.
  function automatic logic [WIDTH-1:0] xtime(input logic [WIDTH-1:0] a);
    return {a[WIDTH-2:0], 1'b0} ^ (a[WIDTH-1] ? WIDTH'(8'h1b) : '0);
  endfunction

  // Byte multiplier by 1, 2 or 3; op 00 is never selected.
  function automatic logic [WIDTH-1:0] gf_mul(input logic [1:0] op,
                                               input logic [WIDTH-1:0] a);
    logic [WIDTH-1:0] r;
    case (op)
      OP_X1:   r = a;
      OP_X2:   r = xtime(a);
      OP_X3:   r = xtime(a) ^ a;
      default: r = '0;
    endcase
    return r;
  endfunction

  logic [1:0]                   state_q;
  logic [CNT_W-1:0]             col_q;
  logic                         byp_q;
  logic [N_COLS-1:0][COL_W-1:0] buf_q;
  logic [N_COLS-1:0][COL_W-1:0] res_q;

  logic [COL_W-1:0] cur_col;
  logic [COL_W-1:0] mix_col;
  logic [WIDTH-1:0] a_byte [4];
  logic [WIDTH-1:0] m_byte [4];

  // Column 0 is the most significant packed element, hence the reversal.
  assign cur_col = buf_q[LAST_COL - col_q];

  // Each row is the same circulant pattern 2,3,1,1 rotated by the row index.
  for (genvar r = 0; r < 4; r++) begin : g_row
    assign a_byte[r] = cur_col[COL_W-1-WIDTH*r -: WIDTH];
    assign m_byte[r] = gf_mul(OP_X2, a_byte[r])
                     ^ gf_mul(OP_X3, a_byte[(r+1)%4])
                     ^ gf_mul(OP_X1, a_byte[(r+2)%4])
                     ^ gf_mul(OP_X1, a_byte[(r+3)%4]);
  end

  assign mix_col = {m_byte[0], m_byte[1], m_byte[2], m_byte[3]};

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      col_q   <= '0;
      byp_q   <= 1'b0;
      buf_q   <= '0;
      res_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.in_valid_i) begin
            buf_q   <= bus.data_i;
            byp_q   <= bus.bypass_i;
            col_q   <= '0;
            state_q <= CALC;
          end
        end
        CALC: begin
          res_q[LAST_COL - col_q] <= byp_q ? cur_col : mix_col;
          if (col_q == LAST_COL) begin
            col_q   <= '0;
            state_q <= DONE;
          end else begin
            col_q <= col_q + 1'b1;
          end
        end
        DONE: begin
          if (bus.out_ready_i) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Outputs depend only on registered state, never on the live handshake inputs.
  assign bus.in_ready_o  = (state_q == IDLE);
  assign bus.out_valid_o = (state_q == DONE);
  assign bus.data_o      = res_q;

endmodule

// File: tb/tb_mix_columns_seq.sv
// tb_mix_columns_seq
//   Scoreboard bench for mix_columns_seq: accepted states push their expected
//   result and accept edge; an output monitor pops and compares data and
//   latency on every output handshake.
module tb_mix_columns_seq;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mix_columns_seq_if mc_if ();

  mix_columns_seq dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (mc_if)
  );

  localparam logic [127:0] V1_IN  = 128'hd4bf5d30_e0b452ae_b84111f1_1e2798e5;
  localparam logic [127:0] V1_OUT = 128'h046681e5_e0cb199a_48f8d37a_2806264c;
  localparam logic [127:0] KC_IN  = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
  localparam logic [127:0] KC_OUT = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
  localparam logic [127:0] KR_IN  = 128'hf20a225c_01010101_c6c6c6c6_db135345;
  localparam logic [127:0] KR_OUT = 128'h9fdc589d_01010101_c6c6c6c6_8e4da1bc;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [127:0] exp_q [$];
  int           acc_q [$];
  int           out_edges [$];
  logic [127:0] cur_exp = '0;
  int           n_cmp = 0;
  int           n_err = 0;

  task automatic check(input string name, input logic [127:0] act,
                       input logic [127:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  // Accept side of the scoreboard.
  always @(negedge clk) begin
    if (rst_n && mc_if.in_valid_i && mc_if.in_ready_o) begin
      exp_q.push_back(cur_exp);
      acc_q.push_back(cyc + 1);
    end
  end

  // Output monitor.
  logic prev_v = 1'b0;
  int   rise_q = 0;
  always @(negedge clk) begin
    int re;
    int acc;
    re = rise_q;
    if (!rst_n) begin
      prev_v <= 1'b0;
    end else begin
      if (mc_if.out_valid_o && !prev_v) re = cyc;
      rise_q <= re;
      prev_v <= mc_if.out_valid_o && !mc_if.out_ready_i;
      if (mc_if.out_valid_o && mc_if.out_ready_i) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_output: got %h, required no output", mc_if.data_o);
        end else begin
          check("result_data", mc_if.data_o, exp_q.pop_front());
          acc = acc_q.pop_front();
          check("latency", 128'(re - acc), 128'(4));
          out_edges.push_back(re);
        end
      end
    end
  end

  task automatic send(input logic [127:0] d, input logic byp, input logic [127:0] e);
    bit ok;
    ok = 1'b0;
    @(posedge clk);
    #1;
    mc_if.in_valid_i = 1'b1;
    mc_if.data_i     = d;
    mc_if.bypass_i   = byp;
    cur_exp          = e;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (mc_if.in_ready_o) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk);
    #1;
    mc_if.in_valid_i = 1'b0;
    if (!ok) begin
      n_cmp++;
      n_err++;
      $display("FAIL accept_timeout: got no accept, required accept within 50 cycles");
    end
  endtask

  task automatic drain();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_cmp++;
      n_err++;
      $display("FAIL drain_timeout: got %0d pending, required 0", exp_q.size());
    end
  endtask

  initial begin
    int base;
    bit seen;
    mc_if.in_valid_i  = 1'b0;
    mc_if.bypass_i    = 1'b0;
    mc_if.data_i      = '0;
    mc_if.out_ready_i = 1'b1;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_out_valid", 128'(mc_if.out_valid_o), 128'(0));
    check("reset_data_o", mc_if.data_o, '0);
    check("reset_in_ready", 128'(mc_if.in_ready_o), 128'(1));
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // FIPS-197 vector, known columns, bypass
    send(V1_IN, 1'b0, V1_OUT);
    drain();
    send(KC_IN, 1'b0, KC_OUT);
    drain();
    send(V1_IN, 1'b1, V1_IN);
    drain();

    // Backpressure
    mc_if.out_ready_i = 1'b0;
    send(KR_IN, 1'b0, KR_OUT);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (mc_if.out_valid_o) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("bp_valid_seen", 128'(seen), 128'(1));
    for (int i = 0; i < 10; i++) begin
      check("bp_data_stable", mc_if.data_o, KR_OUT);
      check("bp_in_ready", 128'(mc_if.in_ready_o), 128'(0));
      check("bp_out_valid", 128'(mc_if.out_valid_o), 128'(1));
      @(posedge clk);
      #1;
      if (i == 2) begin
        mc_if.in_valid_i = 1'b1;
        mc_if.data_i     = '0;
        cur_exp          = '0;
      end
      if (i == 5) mc_if.in_valid_i = 1'b0;
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    mc_if.out_ready_i = 1'b1;
    drain();
    @(negedge clk);
    check("bp_back_idle_ready", 128'(mc_if.in_ready_o), 128'(1));
    check("bp_back_idle_valid", 128'(mc_if.out_valid_o), 128'(0));
    repeat (8) @(negedge clk);
    check("bp_no_extra_accept", 128'(exp_q.size()), 128'(0));
    check("bp_no_extra_output", 128'(mc_if.out_valid_o), 128'(0));

    // Back-to-back
    base = out_edges.size();
    send(V1_IN, 1'b0, V1_OUT);
    send(KC_IN, 1'b0, KC_OUT);
    send(KR_IN, 1'b0, KR_OUT);
    drain();
    if (out_edges.size() >= base + 3) begin
      check("b2b_spacing_1", 128'(out_edges[base+1] - out_edges[base]), 128'(6));
      check("b2b_spacing_2", 128'(out_edges[base+2] - out_edges[base+1]), 128'(6));
    end else begin
      n_cmp++;
      n_err++;
      $display("FAIL b2b_count: got %0d outputs, required 3", out_edges.size() - base);
    end

    // Reset two clocks into CALC
    send(V1_IN, 1'b0, V1_OUT);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    exp_q.delete();
    acc_q.delete();
    #1;
    check("rst_mid_out_valid", 128'(mc_if.out_valid_o), 128'(0));
    check("rst_mid_data_o", mc_if.data_o, '0);
    check("rst_mid_in_ready", 128'(mc_if.in_ready_o), 128'(1));
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    check("rst_no_partial_output", 128'(mc_if.out_valid_o), 128'(0));
    check("rst_release_ready", 128'(mc_if.in_ready_o), 128'(1));
    send(KC_IN, 1'b0, KC_OUT);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no completion, required finish before 200000");
    $fatal(1);
  end

endmodule
